// File: rtl/com_pkg.sv
// Shared types, widths and parameter defaults for the center-of-mass scheduler.
package com_pkg;

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned AW = 32;

    localparam int unsigned H_ACTIVE_DEF = 1024;
    localparam int unsigned V_ACTIVE_DEF = 768;
    localparam int unsigned MIN_MASS_DEF = 16;
    localparam int unsigned TIMEOUT_DEF  = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StReqX,
        StWaitX,
        StReqY,
        StWaitY,
        StDone
    } com_state_t;

    // Saturate a full-width quotient before it is truncated to a coordinate.
    function automatic logic [AW-1:0] clamp_max(input logic [AW-1:0] value,
                                                 input logic [AW-1:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/com_scheduler_if.sv
// Request/response link between the scheduler and the shared divider.
interface com_scheduler_if;
    import com_pkg::*;

    logic [AW-1:0] div_dividend_out;
    logic [AW-1:0] div_divisor_out;
    logic          div_valid_out;
    logic [AW-1:0] div_quotient_in;
    logic          div_valid_in;

    modport master (
        output div_dividend_out,
        output div_divisor_out,
        output div_valid_out,
        input  div_quotient_in,
        input  div_valid_in
    );

    modport slave (
        input  div_dividend_out,
        input  div_divisor_out,
        input  div_valid_out,
        output div_quotient_in,
        output div_valid_in
    );

endinterface

// File: rtl/com_frame_sync.sv
// Detects the last active pixel of a frame and fires once per frame, even if
// the raster counters stall on that position.
module com_frame_sync
    import com_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [XW-1:0] hcount_in,
    input  logic [YW-1:0] vcount_in,
    output logic          frame_end_out
);

    logic at_end;
    logic at_end_q;

    assign at_end = (hcount_in == XW'(H_ACTIVE - 1)) && (vcount_in == YW'(V_ACTIVE - 1));

    // Remember whether the previous cycle was already at the frame end.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            at_end_q <= 1'b0;
        end else begin
            at_end_q <= at_end;
        end
    end

    assign frame_end_out = at_end && !at_end_q;

endmodule

// File: rtl/com_scheduler.sv
// Frame-level controller: snapshots accumulator totals at frame end, runs the
// x and y divides through one shared divider and publishes a clamped centroid.
module com_scheduler
    import com_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned MIN_MASS = MIN_MASS_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [XW-1:0]          hcount_in,
    input  logic [YW-1:0]          vcount_in,
    input  logic [AW-1:0]          x_total_in,
    input  logic [AW-1:0]          y_total_in,
    input  logic [AW-1:0]          mass_in,
    output logic                   acc_clear_out,
    com_scheduler_if.master        div,
    output logic [XW-1:0]          x_out,
    output logic [YW-1:0]          y_out,
    output logic                   valid_out,
    output logic                   found_out,
    output logic                   timeout_out,
    output logic [7:0]             overrun_count_out
);

    localparam int unsigned CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
    localparam logic [AW-1:0] XMax    = AW'(H_ACTIVE - 1);
    localparam logic [AW-1:0] YMax    = AW'(V_ACTIVE - 1);
    localparam logic [AW-1:0] MinMass = AW'(MIN_MASS);

    com_state_t    state_q, state_d;
    logic [AW-1:0] y_total_q, y_total_d;
    logic [AW-1:0] dividend_q, dividend_d;
    logic [AW-1:0] divisor_q, divisor_d;
    logic [AW-1:0] qx_q, qx_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          found_q, found_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    overrun_q, overrun_d;
    logic          frame_end;

    com_frame_sync #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_sync (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .frame_end_out (frame_end)
    );

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            y_total_q  <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            qx_q       <= '0;
            wait_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            found_q    <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= '0;
        end else begin
            state_q    <= state_d;
            y_total_q  <= y_total_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            qx_q       <= qx_d;
            wait_cnt_q <= wait_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            found_q    <= found_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    // Sequencer: dividend/divisor are loaded on entry to each request state so
    // they are stable during the request and held afterwards.
    always_comb begin
        state_d    = state_q;
        y_total_d  = y_total_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        qx_d       = qx_q;
        wait_cnt_d = wait_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        found_d    = found_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (frame_end) state_d = StLatch;
            end
            StLatch: begin
                // x total and mass live in the dividend/divisor registers.
                y_total_d = y_total_in;
                if (mass_in < MinMass) begin
                    found_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    dividend_d = x_total_in;
                    divisor_d  = mass_in;
                    state_d    = StReqX;
                end
            end
            StReqX: begin
                wait_cnt_d = '0;
                state_d    = StWaitX;
            end
            StWaitX: begin
                if (div.div_valid_in) begin
                    qx_d       = div.div_quotient_in;
                    dividend_d = y_total_q;
                    state_d    = StReqY;
                end else if (wait_cnt_q == CntLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StReqY: begin
                wait_cnt_d = '0;
                state_d    = StWaitY;
            end
            StWaitY: begin
                if (div.div_valid_in) begin
                    x_d     = XW'(clamp_max(qx_q, XMax));
                    y_d     = YW'(clamp_max(div.div_quotient_in, YMax));
                    found_d = 1'b1;
                    state_d = StDone;
                end else if (wait_cnt_q == CntLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Count frame ends that arrive while a frame is still being processed.
    always_comb begin
        overrun_d = overrun_q;
        if (frame_end && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    assign acc_clear_out        = (state_q == StLatch);
    assign div.div_valid_out    = (state_q == StReqX) || (state_q == StReqY);
    assign div.div_dividend_out = dividend_q;
    assign div.div_divisor_out  = divisor_q;
    assign valid_out            = (state_q == StDone);
    assign x_out                = x_q;
    assign y_out                = y_q;
    assign found_out            = found_q;
    assign timeout_out          = timeout_q;
    assign overrun_count_out    = overrun_q;

endmodule

// File: tb/tb_com_scheduler.sv
// Directed bench for com_scheduler with a behavioural divider and accumulator.
// The reference model predicts, per frame end, the cycle of every pulse and the
// new held output values from the timing rules and plain division.
module tb_com_scheduler;
    import com_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int EvClr = 0, EvReq = 1, EvValid = 2, EvX = 3, EvY = 4;
    localparam int EvFound = 5, EvTimeout = 6, EvOverrun = 7, EvZero = 8;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [31:0] acc_x, acc_y, acc_m;
    logic [31:0] inc_x, inc_y, inc_m;
    logic        acc_clear_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out, found_out, timeout_out;
    logic [7:0]  overrun_count_out;

    com_scheduler_if dif ();

    com_scheduler #(
        .H_ACTIVE (1024),
        .V_ACTIVE (768),
        .MIN_MASS (16),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .x_total_in        (acc_x),
        .y_total_in        (acc_y),
        .mass_in           (acc_m),
        .acc_clear_out     (acc_clear_out),
        .div               (dif),
        .x_out             (x_out),
        .y_out             (y_out),
        .valid_out         (valid_out),
        .found_out         (found_out),
        .timeout_out       (timeout_out),
        .overrun_count_out (overrun_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Accumulator stand-in: cleared by the scheduler, fed by the stimulus.
    always @(posedge clk_in) begin
        if (rst_in || acc_clear_out) begin
            acc_x <= 0; acc_y <= 0; acc_m <= 0;
        end else begin
            acc_x <= acc_x + inc_x; acc_y <= acc_y + inc_y; acc_m <= acc_m + inc_m;
        end
    end

    int n_checks = 0, n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    ev_t         evq[$];
    logic [31:0] pend_x = 0, pend_y = 0, pend_m = 0;
    int          idle_from = 0;
    int          m_ovr = 0;
    int          div_d = 5;

    task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] b);
        evq.push_back('{cyc: c, kind: k, a: a, b: b});
    endtask

    function automatic logic [31:0] min32(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic predict(input int t);
        logic [31:0] sx, sy, sm;
        int v;
        if (t < idle_from) begin
            if (m_ovr < 255) m_ovr++;
            push(t + 1, EvOverrun, m_ovr, 0);
            return;
        end
        sx = pend_x; sy = pend_y; sm = pend_m;
        pend_x = 0; pend_y = 0; pend_m = 0;
        push(t + 1, EvClr, 0, 0);
        if (sm < 16) begin
            push(t + 2, EvFound, 0, 0);
            idle_from = t + 2;
            return;
        end
        push(t + 2, EvReq, sx, sm);
        if (div_d == 0 || div_d > TIMEOUT) begin
            push(t + 3 + TIMEOUT, EvTimeout, 1, 0);
            idle_from = t + 3 + TIMEOUT;
        end else begin
            push(t + 3 + div_d, EvReq, sy, sm);
            v = t + 4 + 2 * div_d;
            push(v, EvValid, 0, 0);
            push(v, EvX, min32(sx / sm, 1023), 0);
            push(v, EvY, min32(sy / sm, 767), 0);
            push(v, EvFound, 1, 0);
            idle_from = v + 1;
        end
    endtask

    task automatic model_reset(input int r);
        for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].cyc > r) evq.delete(i);
        push(r + 1, EvZero, 0, 0);
        idle_from = r + 1;
        m_ovr = 0;
        pend_x = 0; pend_y = 0; pend_m = 0;
    endtask

    // ---------------- compare + divider model ----------------
    logic [31:0] exp_x = 0, exp_y = 0;
    logic        exp_found = 0, exp_to = 0;
    logic [31:0] exp_ovr = 0;
    int last_clr_cyc = -1, last_req = -1, prev_req = -1, last_valid_cyc = -1;
    int clr_count = 0, req_count = 0, valid_count = 0;
    bit          resp_pending = 1'b0;
    int          resp_cyc = 0;
    logic [31:0] resp_q = 0;

    always @(negedge clk_in) begin : cmp_blk
        logic        e_clr, e_req, e_val;
        logic [31:0] e_dvd, e_dvs;
        e_clr = 0; e_req = 0; e_val = 0; e_dvd = 0; e_dvs = 0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].cyc == cyc) begin
                case (evq[i].kind)
                    EvClr:     e_clr = 1;
                    EvReq:     begin e_req = 1; e_dvd = evq[i].a; e_dvs = evq[i].b; end
                    EvValid:   e_val = 1;
                    EvX:       exp_x = evq[i].a;
                    EvY:       exp_y = evq[i].a;
                    EvFound:   exp_found = evq[i].a[0];
                    EvTimeout: exp_to = evq[i].a[0];
                    EvOverrun: exp_ovr = evq[i].a;
                    default: begin
                        exp_x = 0; exp_y = 0; exp_found = 0; exp_to = 0; exp_ovr = 0;
                    end
                endcase
                evq.delete(i);
            end
        end
        if (chk_en) begin
            chk("acc_clear", acc_clear_out, e_clr);
            chk("div_valid", dif.div_valid_out, e_req);
            if (e_req) begin
                chk("div_dividend", dif.div_dividend_out, e_dvd);
                chk("div_divisor", dif.div_divisor_out, e_dvs);
            end
            chk("valid", valid_out, e_val);
            chk("x_out", x_out, exp_x);
            chk("y_out", y_out, exp_y);
            chk("found", found_out, exp_found);
            chk("timeout", timeout_out, exp_to);
            chk("overrun", overrun_count_out, exp_ovr);
        end
        if (acc_clear_out) begin last_clr_cyc = cyc; clr_count++; end
        if (dif.div_valid_out) begin prev_req = last_req; last_req = cyc; req_count++; end
        if (valid_out) begin last_valid_cyc = cyc; valid_count++; end
        // Behavioural divider: answers D cycles after a request (D == 0: never).
        dif.div_valid_in = 1'b0;
        if (resp_pending && resp_cyc == cyc) begin
            dif.div_valid_in    = 1'b1;
            dif.div_quotient_in = resp_q;
            resp_pending        = 1'b0;
        end
        if (dif.div_valid_out === 1'b1 && div_d != 0) begin
            resp_pending = 1'b1;
            resp_cyc     = cyc + div_d;
            resp_q       = dif.div_dividend_out / dif.div_divisor_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next();
    endtask

    task automatic add_px(input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dm);
        inc_x = dx; inc_y = dy; inc_m = dm;
        pend_x += dx; pend_y += dy; pend_m += dm;
        next();
        inc_x = 0; inc_y = 0; inc_m = 0;
    endtask

    task automatic frame(input int stall, output int t);
        hcount_in = 11'd1023;
        vcount_in = 10'd767;
        t = cyc;
        predict(t);
        repeat (stall) next();
        hcount_in = 0;
        vcount_in = 0;
    endtask

    initial begin
        int t, t1, base_req, base_val, base_clr;
        rst_in = 1'b1; hcount_in = 0; vcount_in = 0;
        inc_x = 0; inc_y = 0; inc_m = 0;
        repeat (3) next();
        chk_en = 1'b1;
        rst_in = 1'b0;
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_found", found_out, 0);
        chk("rst_timeout", timeout_out, 0);
        chk("rst_overrun", overrun_count_out, 0);
        chk("rst_div_valid", dif.div_valid_out, 0);

        // Normal frame, D=5, raster stalled on the last pixel for 3 cycles.
        div_d = 5;
        add_px(5000, 3000, 100);
        next();
        frame(3, t);
        wait_until(t + 20);
        chk("t1_clear_cyc", last_clr_cyc, t + 1);
        chk("t1_req_x_cyc", prev_req, t + 2);
        chk("t1_req_y_cyc", last_req, t + 8);
        chk("t1_valid_cyc", last_valid_cyc, t + 14);
        chk("t1_x", x_out, 50);
        chk("t1_y", y_out, 30);
        chk("t1_found", found_out, 1);

        // Mass below threshold: no divides, position held.
        base_req = req_count; base_val = valid_count;
        add_px(100, 100, 10);
        next();
        frame(1, t);
        wait_until(t + 10);
        chk("t2_no_req", req_count, base_req);
        chk("t2_no_valid", valid_count, base_val);
        chk("t2_found", found_out, 0);
        chk("t2_x_held", x_out, 50);
        chk("t2_y_held", y_out, 30);

        // Quotients 2000 and 900 clamp to the last active pixel.
        div_d = 3;
        add_px(200000, 90000, 100);
        next();
        frame(1, t);
        wait_until(t + 14);
        chk("t3_x_clamp", x_out, 1023);
        chk("t3_y_clamp", y_out, 767);

        // Divider silent: timeout, then a normal frame.
        div_d = 0;
        add_px(1600, 1600, 16);
        next();
        frame(1, t);
        wait_until(t + 66);
        chk("t4_no_timeout_yet", timeout_out, 0);
        next();
        chk("t4_timeout", timeout_out, 1);
        wait_until(t + 80);
        chk("t4_x_held", x_out, 1023);
        chk("t4_found_held", found_out, 1);
        div_d = 4;
        add_px(3200, 1600, 32);
        next();
        frame(1, t);
        wait_until(t + 16);
        chk("t4_next_x", x_out, 100);
        chk("t4_next_y", y_out, 50);
        chk("t4_timeout_sticky", timeout_out, 1);

        // Slow divider: a frame end dropped (coinciding with the x result)
        // folds its pixels into the following snapshot.
        div_d = 30;
        base_clr = clr_count;
        add_px(640, 320, 64);
        next();
        frame(1, t1);
        wait_until(t1 + 10);
        add_px(6400, 3200, 64);
        wait_until(t1 + 32);
        frame(1, t);
        wait_until(t1 + 70);
        chk("t5_overrun", overrun_count_out, 1);
        chk("t5_first_x", x_out, 10);
        chk("t5_one_clear", clr_count, base_clr + 1);
        div_d = 2;
        add_px(640, 640, 64);
        next();
        frame(1, t);
        wait_until(t + 12);
        chk("t5_fold_x", x_out, 55);
        chk("t5_fold_y", y_out, 30);

        // Reset during WAIT_Y; the stray result afterwards is ignored.
        div_d = 10;
        add_px(1000, 1000, 20);
        next();
        frame(1, t);
        wait_until(t + 16);
        base_val = valid_count;
        rst_in = 1'b1;
        model_reset(cyc);
        next();
        rst_in = 1'b0;
        wait_until(t + 40);
        chk("t6_no_valid", valid_count, base_val);
        chk("t6_x", x_out, 0);
        chk("t6_y", y_out, 0);
        chk("t6_found", found_out, 0);
        chk("t6_timeout", timeout_out, 0);
        chk("t6_overrun", overrun_count_out, 0);

        // Recovery after reset.
        div_d = 1;
        add_px(3000, 2000, 100);
        next();
        frame(1, t);
        wait_until(t + 10);
        chk("t7_valid_cyc", last_valid_cyc, t + 6);
        chk("t7_x", x_out, 30);
        chk("t7_y", y_out, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
